// File: rtl/erozyon_pkg.sv
// erozyon_pkg: shared types and constants for the erosion sequencer.
// Holds the FSM state enum, the row/column offset tables that map window
// index k=0..8 to a neighbour offset, and the default pad value.
package erozyon_pkg;
  typedef enum logic [2:0] {BOSTA, OKU, ISLE, YAZ, BITTI} durum_t;
  localparam int SATIR_OFS [9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int SUTUN_OFS [9] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
  localparam logic [7:0] VARSAYILAN_KENAR = 8'hFF;
endpackage

// File: rtl/erozyon_kontrol_if.sv
// erozyon_kontrol_if: bus between the sequencer, the image RAMs and the erosion unit.
// Carries start/status, RAM read strobe/address/data, the 3x3 window g0..g8,
// unit enable/result and RAM write strobe/address/data.
// master = sequencer side, slave = environment (RAMs + unit) side.
interface erozyon_kontrol_if #(parameter int ADR_W = 16);
  logic basla_i, oku_en_o, birim_en_o, yaz_en_o, mesgul_o, bitti_o;
  logic [ADR_W-1:0] oku_adr_o, yaz_adr_o;
  logic [7:0] oku_veri_i, birim_veri_i, yaz_veri_o;
  logic [7:0] g0_o, g1_o, g2_o, g3_o, g4_o, g5_o, g6_o, g7_o, g8_o;
  modport master (
    input basla_i, oku_veri_i, birim_veri_i,
    output oku_en_o, oku_adr_o, birim_en_o, yaz_en_o, yaz_adr_o, yaz_veri_o, mesgul_o, bitti_o,
    output g0_o, g1_o, g2_o, g3_o, g4_o, g5_o, g6_o, g7_o, g8_o
  );
  modport slave (
    output basla_i, oku_veri_i, birim_veri_i,
    input oku_en_o, oku_adr_o, birim_en_o, yaz_en_o, yaz_adr_o, yaz_veri_o, mesgul_o, bitti_o,
    input g0_o, g1_o, g2_o, g3_o, g4_o, g5_o, g6_o, g7_o, g8_o
  );
endinterface

// File: rtl/erozyon_kontrol_pencere_adres.sv
// pencere_adres: neighbour address generator for one window slot.
// Ports: r, c = current pixel; k = window index 0..8;
// gecerli = neighbour lies inside the image; adr = its row-major address (0 when outside).
module pencere_adres import erozyon_pkg::*; #(
  parameter int GENISLIK = 8,
  parameter int YUKSEKLIK = 8,
  parameter int ADR_W = 16
) (
  input  logic [ADR_W-1:0] r,
  input  logic [ADR_W-1:0] c,
  input  logic [3:0]       k,
  output logic             gecerli,
  output logic [ADR_W-1:0] adr
);
  int rr, cc;
  always_comb begin
    rr = int'(r) + SATIR_OFS[k];
    cc = int'(c) + SUTUN_OFS[k];
  end
  assign gecerli = rr >= 0 && rr < YUKSEKLIK && cc >= 0 && cc < GENISLIK;
  assign adr = gecerli ? ADR_W'(rr * GENISLIK + cc) : '0;
endmodule

// File: rtl/erozyon_kontrol.sv
// erozyon_kontrol: runs the 3x3 erosion unit over a whole image, pixel by pixel.
// Ports: clk_i, rst_i (sync, active-low); bus (master) carries basla_i,
// RAM read oku_en_o/oku_adr_o/oku_veri_i, window g0_o..g8_o, unit
// birim_en_o/birim_veri_i, RAM write yaz_en_o/yaz_adr_o/yaz_veri_o, mesgul_o, bitti_o.
module erozyon_kontrol import erozyon_pkg::*; #(
  parameter int GENISLIK = 8,
  parameter int YUKSEKLIK = 8,
  parameter int ADR_W = 16,
  parameter logic [7:0] KENAR_DEGER = VARSAYILAN_KENAR,
  parameter int BIRIM_GECIKME = 15
) (
  input logic clk_i,
  input logic rst_i,
  erozyon_kontrol_if.master bus
);
  durum_t durum;
  logic [ADR_W-1:0] r, c, r_sec, c_sec, adr;
  logic [3:0] say, k_sec;
  logic [15:0] sayac;
  logic [7:0] pencere [9];
  logic oku_onceki, gecerli, son, c_son, yeni_oku;
  assign c_son = c == ADR_W'(GENISLIK - 1);
  assign son = c_son && r == ADR_W'(YUKSEKLIK - 1);
  // A slot is issued when entering OKU (from BOSTA or YAZ) and on each OKU cycle until k=8.
  assign yeni_oku = (durum == BOSTA && bus.basla_i) || (durum == OKU && say < 4'd8) || (durum == YAZ && !son);
  // Issue addresses are computed for the pixel about to be fetched, so YAZ looks one pixel ahead.
  assign r_sec = durum == BOSTA ? '0 : (durum == YAZ && c_son) ? r + 1'b1 : r;
  assign c_sec = (durum == BOSTA || (durum == YAZ && c_son)) ? '0 : durum == YAZ ? c + 1'b1 : c;
  assign k_sec = (durum == OKU && say < 4'd8) ? say + 4'd1 : 4'd0;
  pencere_adres #(.GENISLIK(GENISLIK), .YUKSEKLIK(YUKSEKLIK), .ADR_W(ADR_W)) u_adres (
    .r(r_sec), .c(c_sec), .k(k_sec), .gecerli(gecerli), .adr(adr)
  );
  assign bus.g0_o = pencere[0];
  assign bus.g1_o = pencere[1];
  assign bus.g2_o = pencere[2];
  assign bus.g3_o = pencere[3];
  assign bus.g4_o = pencere[4];
  assign bus.g5_o = pencere[5];
  assign bus.g6_o = pencere[6];
  assign bus.g7_o = pencere[7];
  assign bus.g8_o = pencere[8];
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      durum <= BOSTA;
      r <= '0;
      c <= '0;
      say <= '0;
      sayac <= '0;
      oku_onceki <= 1'b0;
      pencere <= '{default: '0};
      bus.oku_en_o <= 1'b0;
      bus.oku_adr_o <= '0;
      bus.birim_en_o <= 1'b0;
      bus.yaz_en_o <= 1'b0;
      bus.yaz_adr_o <= '0;
      bus.yaz_veri_o <= '0;
      bus.mesgul_o <= 1'b0;
      bus.bitti_o <= 1'b0;
    end else begin
      oku_onceki <= bus.oku_en_o;
      bus.oku_en_o <= yeni_oku && gecerli;
      if (yeni_oku) bus.oku_adr_o <= adr;
      // Out-of-image slots are padded at issue time; no read is made for them.
      if (yeni_oku && !gecerli) pencere[k_sec] <= KENAR_DEGER;
      case (durum)
        BOSTA: if (bus.basla_i) begin
          durum <= OKU;
          bus.mesgul_o <= 1'b1;
          r <= '0;
          c <= '0;
          say <= '0;
        end
        OKU: begin
          // Data for the slot issued last cycle is valid now.
          if (say != 4'd0 && oku_onceki) pencere[say - 4'd1] <= bus.oku_veri_i;
          say <= say + 4'd1;
          if (say == 4'd9) begin
            durum <= ISLE;
            sayac <= '0;
            bus.birim_en_o <= 1'b1;
          end
        end
        ISLE: begin
          sayac <= sayac + 16'd1;
          if (sayac == 16'(BIRIM_GECIKME - 1)) begin
            durum <= YAZ;
            bus.birim_en_o <= 1'b0;
            bus.yaz_en_o <= 1'b1;
            bus.yaz_adr_o <= r * ADR_W'(GENISLIK) + c;
            bus.yaz_veri_o <= bus.birim_veri_i;
          end
        end
        YAZ: begin
          bus.yaz_en_o <= 1'b0;
          if (son) begin
            durum <= BITTI;
            bus.bitti_o <= 1'b1;
            bus.mesgul_o <= 1'b0;
          end else begin
            durum <= OKU;
            say <= '0;
            r <= r_sec;
            c <= c_sec;
          end
        end
        BITTI: begin
          bus.bitti_o <= 1'b0;
          durum <= BOSTA;
        end
        default: durum <= BOSTA;
      endcase
    end
  end
endmodule
